// File: rtl/aes_round_seq_pkg.sv
// Shared types, widths and GF(2^8) helpers for the iterative AES round sequencer.
// The S-box is computed as the GF inverse followed by the affine map, so no ROM table is needed.
package aes_round_seq_pkg;

    localparam int NR_DEF  = 10;
    localparam int BLOCK_W = 128;
    localparam int NB      = BLOCK_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY0  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } fsm_e;

    function automatic int key_idx_w(input int nr);
        return $clog2(nr + 1);
    endfunction

    // Byte 0 lives in the top byte lane of a block.
    function automatic int byte_msb(input int i);
        return BLOCK_W - 1 - 8 * i;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Block-in / key-request / block-out signal bundle of the AES round sequencer.
// Signal names carry the sequencer's point of view (i_ = into the sequencer).
interface aes_round_seq_if
    import aes_round_seq_pkg::*;
#(
    parameter int NR = NR_DEF
);
    localparam int CW = key_idx_w(NR);

    logic               i_valid;
    logic               o_ready;
    logic [BLOCK_W-1:0] i_block;
    logic               o_key_req;
    logic [CW-1:0]      o_key_idx;
    logic [BLOCK_W-1:0] i_key;
    logic               i_key_vld;
    logic               o_valid;
    logic               i_ready;
    logic [BLOCK_W-1:0] o_block;

    modport master (
        output i_valid, i_block, i_key, i_key_vld, i_ready,
        input  o_ready, o_key_req, o_key_idx, o_valid, o_block
    );

    modport slave (
        input  i_valid, i_block, i_key, i_key_vld, i_ready,
        output o_ready, o_key_req, o_key_idx, o_valid, o_block
    );

endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// mix_en is low only for the last round.
module aes_round_comb
    import aes_round_seq_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] key,
    input  logic               mix_en,
    output logic [BLOCK_W-1:0] next_state
);

    logic [BLOCK_W-1:0] sub_v;
    logic [BLOCK_W-1:0] shf_v;
    logic [BLOCK_W-1:0] mix_v;

    genvar gi;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_sub
            assign sub_v[byte_msb(gi) -: 8] = sbox(state[byte_msb(gi) -: 8]);
        end

        // Row r of column c takes the byte from column (c + r) mod 4.
        for (gi = 0; gi < NB; gi++) begin : g_shift
            localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
            assign shf_v[byte_msb(gi) -: 8] = sub_v[byte_msb(SRC) -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0;
            logic [7:0] a1;
            logic [7:0] a2;
            logic [7:0] a3;
            assign a0 = shf_v[byte_msb(4 * gi)     -: 8];
            assign a1 = shf_v[byte_msb(4 * gi + 1) -: 8];
            assign a2 = shf_v[byte_msb(4 * gi + 2) -: 8];
            assign a3 = shf_v[byte_msb(4 * gi + 3) -: 8];
            assign mix_v[byte_msb(4 * gi)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix_v[byte_msb(4 * gi + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix_v[byte_msb(4 * gi + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix_v[byte_msb(4 * gi + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (gi = 0; gi < NB; gi++) begin : g_ark
            assign next_state[byte_msb(gi) -: 8] =
                (mix_en ? mix_v[byte_msb(gi) -: 8] : shf_v[byte_msb(gi) -: 8])
                ^ key[byte_msb(gi) -: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES encryption sequencer: one round per cycle through a shared combinational round,
// round keys fetched by index from an external key schedule, result held until consumed.
module aes_round_seq
    import aes_round_seq_pkg::*;
#(
    parameter int NR = NR_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    aes_round_seq_if.slave  bus
);

    localparam int            CW        = key_idx_w(NR);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NR - 1);
    localparam logic [CW-1:0] IDX_FINAL = CW'(NR);

    fsm_e               state_reg;
    fsm_e               state_next;
    logic [BLOCK_W-1:0] blk_reg;
    logic [BLOCK_W-1:0] blk_next;
    logic [CW-1:0]      cnt_reg;
    logic [CW-1:0]      cnt_next;

    logic [BLOCK_W-1:0] round_out;
    logic               mix_en;
    logic [CW-1:0]      key_idx;

    aes_round_comb u_round (
        .state      (blk_reg),
        .key        (bus.i_key),
        .mix_en     (mix_en),
        .next_state (round_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            blk_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            blk_reg   <= blk_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Every key-consuming state holds completely while the key schedule stalls.
    always_comb begin
        state_next = state_reg;
        blk_next   = blk_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    blk_next   = bus.i_block;
                    cnt_next   = '0;
                    state_next = ST_KEY0;
                end
            end
            ST_KEY0: begin
                if (bus.i_key_vld) begin
                    blk_next   = blk_reg ^ bus.i_key;
                    cnt_next   = CW'(1);
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (bus.i_key_vld) begin
                    blk_next = round_out;
                    // The counter parks at NR-1; the last round uses the fixed index NR.
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_FINAL;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_FINAL: begin
                if (bus.i_key_vld) begin
                    blk_next   = round_out;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_ready   = 1'b0;
        bus.o_valid   = 1'b0;
        bus.o_key_req = 1'b0;
        bus.o_block   = '0;
        key_idx       = '0;
        mix_en        = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                bus.o_ready = 1'b1;
            end
            ST_KEY0: begin
                bus.o_key_req = 1'b1;
            end
            ST_ROUND: begin
                bus.o_key_req = 1'b1;
                key_idx       = cnt_reg;
            end
            ST_FINAL: begin
                bus.o_key_req = 1'b1;
                key_idx       = IDX_FINAL;
                mix_en        = 1'b0;
            end
            ST_DONE: begin
                bus.o_valid = 1'b1;
                bus.o_block = blk_reg;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_key_idx = key_idx;

endmodule

// File: tb/tb_aes_round_seq.sv
// Randomized self-checking bench for aes_round_seq against a byte-array AES-128 model
// (log/antilog-table S-box, FIPS-197 key expansion) with key stalls, back-pressure and reset.
module tb_aes_round_seq;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_seq_if #(.NR(NR)) bus ();

    aes_round_seq #(.NR(NR)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk     [0:10];
    int           stall_at [0:10];
    int unsigned  accepts [$];
    logic [127:0] last_ct;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3, then the FIPS affine map.
    task automatic build_sbox();
        logic [7:0] exp_t [0:254];
        int         log_t [0:255];
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
            sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r < 10) begin
                    s[4 * c]     = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                    s[4 * c + 3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},   bus.o_ready,   1'b1);
        check_eq({tag, "_valid"},   bus.o_valid,   1'b0);
        check_eq({tag, "_key_req"}, bus.o_key_req, 1'b0);
        check_eq({tag, "_key_idx"}, bus.o_key_idx, 4'd0);
        check_eq({tag, "_block"},   bus.o_block,   128'h0);
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic do_block(input logic [127:0] pt, input int hold_cycles,
                            input bit keep_valid, input logic [127:0] bp_block);
        logic [127:0] exp_ct;
        int           lat;
        int           exp_lat;
        int           k;
        int           used [0:10];
        int           seq [$];
        bit           prev_stall;
        logic [3:0]   prev_idx;
        exp_ct  = model_encrypt(pt);
        exp_lat = 12;
        for (int i = 0; i <= 10; i++) begin
            exp_lat += stall_at[i];
            used[i] = 0;
        end
        check_eq("ready_before_accept", bus.o_ready, 1'b1);
        bus.i_valid = 1'b1;
        bus.i_block = pt;
        @(posedge clk); #1;
        accepts.push_back(cyc);
        if (!keep_valid) bus.i_valid = 1'b0;
        bus.i_block = rand128();
        lat = 1;
        prev_stall = 1'b0;
        prev_idx = '0;
        while (!bus.o_valid && lat < 200) begin
            if (prev_stall) check_eq("idx_stable_in_stall", bus.o_key_idx, prev_idx);
            prev_stall = 1'b0;
            k = int'(bus.o_key_idx);
            bus.i_key = rk[k];
            bus.i_key_vld = 1'b1;
            if (bus.o_key_req) begin
                if (k <= 10 && used[k] < stall_at[k]) begin
                    used[k]++;
                    bus.i_key_vld = 1'b0;
                    bus.i_key = rand128();
                    prev_stall = 1'b1;
                    prev_idx = bus.o_key_idx;
                end else begin
                    seq.push_back(k);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.i_key_vld = 1'b1;
        check_eq("latency", lat, exp_lat);
        check_eq("ciphertext", bus.o_block, exp_ct);
        check_eq("ready_in_done", bus.o_ready, 1'b0);
        check_eq("key_seq_len", seq.size(), 11);
        foreach (seq[i]) check_eq("key_idx_seq", seq[i], i);
        last_ct = bus.o_block;
        $display("blk pt=%h ct=%h lat=%0d hold=%0d", pt, bus.o_block, lat, hold_cycles);
        if (hold_cycles > 0) begin
            bus.i_ready = 1'b0;
            bus.i_valid = 1'b1;
            bus.i_block = bp_block;
            repeat (hold_cycles) begin
                @(posedge clk); #1;
                check_eq("bp_block_stable", bus.o_block, exp_ct);
                check_eq("bp_valid_held", bus.o_valid, 1'b1);
                check_eq("bp_ready_low", bus.o_ready, 1'b0);
            end
            bus.i_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("valid_drop", bus.o_valid, 1'b0);
        check_eq("ready_return", bus.o_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [127:0] blks [4];
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_block = '0;
        bus.i_key = '0;
        bus.i_key_vld = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i <= 10; i++) stall_at[i] = 0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.1, no stalls
        expand_key(FIPS_KEY);
        do_block(FIPS_PT, 0, 1'b0, '0);
        check_eq("fips_c1", last_ct, FIPS_CT);

        // Same vector with one stall cycle at indices 0, 5 and 10
        stall_at[0] = 1; stall_at[5] = 1; stall_at[10] = 1;
        do_block(FIPS_PT, 0, 1'b0, '0);
        check_eq("fips_c1_stalled", last_ct, FIPS_CT);
        for (int i = 0; i <= 10; i++) stall_at[i] = 0;

        // Back-pressure: second block offered during DONE, accepted after release
        expand_key(rand128());
        blks[0] = rand128();
        blks[1] = rand128();
        do_block(blks[0], 20, 1'b0, blks[1]);
        do_block(blks[1], 0, 1'b0, '0);
        check_eq("bp_accept_spacing", accepts[$] - accepts[$-1], 33);

        // Back-to-back with i_valid held high
        expand_key(rand128());
        for (int i = 0; i < 4; i++) blks[i] = rand128();
        for (int i = 0; i < 4; i++) begin
            do_block(blks[i], 0, 1'b1, '0);
            if (i > 0) check_eq("b2b_spacing", accepts[$] - accepts[$-1], 13);
        end
        bus.i_valid = 1'b0;

        // Reset while the round counter is at 5
        expand_key(FIPS_KEY);
        bus.i_valid = 1'b1;
        bus.i_block = FIPS_PT;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 0;
        while (!(bus.o_key_req && bus.o_key_idx == 4'd5) && n < 40) begin
            bus.i_key = rk[int'(bus.o_key_idx)];
            bus.i_key_vld = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check_eq("pre_reset_idx", bus.o_key_idx, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_block(FIPS_PT, 0, 1'b0, '0);
        check_eq("fips_after_reset", last_ct, FIPS_CT);

        // Random keys, blocks and stall patterns
        for (int b = 0; b < 4; b++) begin
            expand_key(rand128());
            for (int i = 0; i <= 10; i++) stall_at[i] = $urandom_range(0, 2);
            do_block(rand128(), $urandom_range(0, 3), 1'b0, rand128());
            bus.i_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
